extram_arbiter: RTL and testbench
=================================

Name: extram_arbiter

Overview:
- Two-port arbiter and sequencer for the single 36-bit pipelined ZBT SRAM on N2x0 (RAM_A/RAM_D/RAM_*n).
- Shares the SRAM between two requesters, port A (RX buffering) and port B (TX buffering), using round-robin with a burst limit.
- Generates ZBT address/control timing and drives the bidirectional data bus through the top-level IOBUF signals (RAM_D_po/RAM_D_pi/RAM_D_poe).
- Inserts a bus-turnaround bubble on every read-to-write transition.

Parameters:
- AWIDTH, 21, SRAM word address width.
- DWIDTH, 36, SRAM data width.
- BURST, 8, maximum consecutive grants to one port while the other port is requesting (valid range 1..255).

Ports:
- clk  in  1  DSP clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  when low, no new grants; in-flight operations complete.
- a_req  in  1  port A request; a_we/a_addr/a_wdata held stable until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  AWIDTH  word address.
- a_wdata  in  DWIDTH  write data.
- a_ack  out  1  one-cycle grant pulse (combinational); command accepted this cycle.
- a_rdata  out  DWIDTH  read data.
- a_rvalid  out  1  one-cycle pulse; a_rdata valid.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_rvalid  same as port A.
- RAM_A  out  AWIDTH  registered address.
- RAM_D_po  out  DWIDTH  registered write data.
- RAM_D_pi  in  DWIDTH  pad input data.
- RAM_D_poe  out  1  IOBUF T; 1 = tristate, 0 = drive.
- RAM_CE1n  out  1  chip select, active low.
- RAM_WEn  out  1  write enable, active low.
- RAM_LDn  out  1  ADV/LD, active low.
- RAM_OEn  out  1  SRAM output enable, active low.
- RAM_CENn  out  1  clock enable, active low.
- busy  out  1  any operation in the 4-stage pipeline.

Behaviour:
- Reset values: RAM_A=0, RAM_D_po=0, RAM_D_poe=1, RAM_CE1n=1, RAM_WEn=1, RAM_LDn=0, RAM_OEn=1, RAM_CENn=1.
- Reset values (continued): all ack/rvalid=0, rdata=0, busy=0, burst counter=0, last-granted pointer=B (so A wins first).
- RAM_CENn goes to 0 on the first clock after reset release and stays 0 thereafter.
- Arbitration (combinational, cycle t): a candidate exists if ena=1 and at least one req is asserted.
  - Only one port requesting: that port is the candidate.
  - Both requesting: the last-granted port keeps priority while burst count < BURST; otherwise the other port.
- Burst counter: +1 on each consecutive grant to the same port; reset to 1 on a port switch; holds while idle.
- Turnaround rule: if the op issued in t-1 was a read and the candidate op is a write, no ack in t. The bubble cycle issues a deselect; grant is re-evaluated in t+1.
- Write-to-read and same-direction back-to-back ops: no bubble; full throughput is one op per cycle.
- Issue: on ack in t, cycle t+1 shows RAM_A=addr, RAM_CE1n=0, RAM_LDn=0, RAM_WEn=~we.
- Idle/bubble cycle pins: RAM_CE1n=1, RAM_LDn=0, RAM_WEn=1 (deselect).
- Pipeline: a 3-deep shift register carries {valid, we, port, wdata}.
- Write: RAM_D_po=wdata and RAM_D_poe=0 during t+3; RAM_OEn=1 during t+3. Otherwise RAM_D_poe=1.
- RAM_OEn=0 in any cycle whose pipeline stage holds a read.
- Read: RAM_D_pi is registered at the end of t+3. {port}_rdata is updated and {port}_rvalid pulses in t+4. Read latency ack-to-rvalid = 4 cycles, fixed.
- rdata holds its value between pulses.
- busy=1 while any pipeline valid bit is set or the output stage is pending.
- ena falling mid-stream: ops already acked complete normally; the pipeline drains. ena rising re-arms immediately.
- a_req dropped before ack: the request is withdrawn with no side effect. Dropping req after ack is legal.
- Address wrap: none. The address is passed through unchanged.

Optional Feature:
- Macro: EXTRAM_STRICT_PRIO_EN.
- Defined: port A has absolute priority whenever a_req=1. The burst counter and BURST are ignored, and port B is granted only when a_req=0. The turnaround rule still applies.
- Undefined: round-robin with burst limit as described in Behaviour.

Test Plan:
- Single A write addr=0x00010, data=0x9_ABCD_1234 -> a_ack in t; RAM_A=0x00010 and RAM_WEn=0 in t+1; RAM_D_po=0x9ABCD1234 with RAM_D_poe=0 in t+3.
- Single B read addr=0x1FFFFF; SRAM model returns 0x0_5555_AAAA -> b_rvalid exactly in t+4 with b_rdata=0x05555AAAA; a_rvalid stays 0.
- A and B both hold req for 40 cycles, all reads, BURST=8 -> grant pattern A×8, B×8, A×8…; 40 acks in 40 cycles.
- Port A read then port A write back-to-back -> no ack in t+1 (deselect on pins in t+2); write acked in t+2; no cycle with RAM_D_poe=0 and RAM_OEn=0.
- Reset asserted mid-burst with 3 ops in flight -> all outputs at reset values immediately (async); no rvalid after release; first grant goes to A.
- EXTRAM_STRICT_PRIO_EN defined, both ports requesting continuously for 20 cycles -> 20 a_acks, 0 b_acks; B granted the first cycle a_req drops.

Source files
------------

// File: rtl/extram_arbiter.sv
// Two-port round-robin arbiter and ZBT SRAM sequencer with read-to-write turnaround.
// Define EXTRAM_STRICT_PRIO_EN to give port A absolute priority instead of burst-limited round-robin.
module extram_arbiter #(
  parameter int AWIDTH = 21,
  parameter int DWIDTH = 36,
  parameter int BURST  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_ack,
  output logic [DWIDTH-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_ack,
  output logic [DWIDTH-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [AWIDTH-1:0] RAM_A,
  output logic [DWIDTH-1:0] RAM_D_po,
  input  logic [DWIDTH-1:0] RAM_D_pi,
  output logic              RAM_D_poe,
  output logic              RAM_CE1n,
  output logic              RAM_WEn,
  output logic              RAM_LDn,
  output logic              RAM_OEn,
  output logic              RAM_CENn,
  output logic              busy
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

`ifndef EXTRAM_STRICT_PRIO_EN
  localparam logic [7:0] BURST_L = 8'(BURST);
`endif

  port_e              last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               cand_vld;
  port_e              cand_port;
  logic               cand_we;
  logic               blocked;
  logic               grant;
  logic [AWIDTH-1:0]  sel_addr;
  logic [DWIDTH-1:0]  sel_wdata;

  logic               p1_vld_q, p2_vld_q, p3_vld_q;
  logic               p1_we_q, p2_we_q, p3_we_q;
  port_e              p1_port_q, p2_port_q, p3_port_q;
  logic [DWIDTH-1:0]  p1_wdata_q, p2_wdata_q;

  logic [AWIDTH-1:0]  ram_a_q;
  logic [DWIDTH-1:0]  ram_po_q;
  logic               ram_poe_q, ram_ce1n_q, ram_wen_q, ram_oen_q, ram_cenn_q;
  logic               a_rvalid_q, b_rvalid_q;
  logic [DWIDTH-1:0]  a_rdata_q, b_rdata_q;

  // Arbitration and turnaround: ack is combinational in the request cycle
  always_comb begin
    cand_vld  = 1'b0;
    cand_port = PORT_A;
    if (rst_n && ena && (a_req || b_req)) begin
      cand_vld = 1'b1;
`ifdef EXTRAM_STRICT_PRIO_EN
      cand_port = a_req ? PORT_A : PORT_B;
`else
      if (a_req && b_req) begin
        // cnt_q==0 only right after reset, so the pointer (B) yields to A first
        if ((cnt_q != 8'd0) && (cnt_q < BURST_L)) cand_port = last_q;
        else                                       cand_port = port_e'(~last_q);
      end else begin
        cand_port = a_req ? PORT_A : PORT_B;
      end
`endif
    end
    cand_we   = (cand_port == PORT_B) ? b_we    : a_we;
    sel_addr  = (cand_port == PORT_B) ? b_addr  : a_addr;
    sel_wdata = (cand_port == PORT_B) ? b_wdata : a_wdata;
    blocked   = p1_vld_q && !p1_we_q && cand_we;
    grant     = cand_vld && !blocked;
    a_ack     = grant && (cand_port == PORT_A);
    b_ack     = grant && (cand_port == PORT_B);
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (grant) begin
      if ((cand_port == last_q) && (cnt_q != 8'd0))
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      else
        cnt_d = 8'd1;
      last_d = cand_port;
    end
  end

  // Control state, pins and read-return stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= PORT_B;
      cnt_q      <= 8'd0;
      p1_vld_q   <= 1'b0;
      p2_vld_q   <= 1'b0;
      p3_vld_q   <= 1'b0;
      ram_a_q    <= '0;
      ram_po_q   <= '0;
      ram_poe_q  <= 1'b1;
      ram_ce1n_q <= 1'b1;
      ram_wen_q  <= 1'b1;
      ram_oen_q  <= 1'b1;
      ram_cenn_q <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      p1_vld_q   <= grant;
      p2_vld_q   <= p1_vld_q;
      p3_vld_q   <= p2_vld_q;
      ram_cenn_q <= 1'b0;
      ram_ce1n_q <= ~grant;
      ram_wen_q  <= ~(grant && cand_we);
      if (grant) ram_a_q <= sel_addr;
      // Data phase is two cycles after address: drive writes / enable reads then
      ram_poe_q  <= ~(p2_vld_q && p2_we_q);
      ram_oen_q  <= ~(p2_vld_q && !p2_we_q);
      if (p2_vld_q && p2_we_q) ram_po_q <= p2_wdata_q;
      a_rvalid_q <= p3_vld_q && !p3_we_q && (p3_port_q == PORT_A);
      b_rvalid_q <= p3_vld_q && !p3_we_q && (p3_port_q == PORT_B);
      if (p3_vld_q && !p3_we_q && (p3_port_q == PORT_A)) a_rdata_q <= RAM_D_pi;
      if (p3_vld_q && !p3_we_q && (p3_port_q == PORT_B)) b_rdata_q <= RAM_D_pi;
    end
  end

  // Pipeline payload; qualified by the valid bits above so no reset needed
  always_ff @(posedge clk) begin
    p1_we_q    <= cand_we;
    p1_port_q  <= cand_port;
    p1_wdata_q <= sel_wdata;
    p2_we_q    <= p1_we_q;
    p2_port_q  <= p1_port_q;
    p2_wdata_q <= p1_wdata_q;
    p3_we_q    <= p2_we_q;
    p3_port_q  <= p2_port_q;
  end

  assign RAM_A     = ram_a_q;
  assign RAM_D_po  = ram_po_q;
  assign RAM_D_poe = ram_poe_q;
  assign RAM_CE1n  = ram_ce1n_q;
  assign RAM_WEn   = ram_wen_q;
  assign RAM_LDn   = 1'b0;
  assign RAM_OEn   = ram_oen_q;
  assign RAM_CENn  = ram_cenn_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = p1_vld_q | p2_vld_q | p3_vld_q | a_rvalid_q | b_rvalid_q;

endmodule

// File: tb/tb_extram_arbiter.sv
// Scoreboard bench for extram_arbiter with a pin-level ZBT SRAM model.
`timescale 1ns/1ps
module tb_extram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [20:0] a_addr = '0, b_addr = '0;
  logic [35:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, a_rvalid, b_rvalid;
  logic [35:0] a_rdata, b_rdata;
  logic [20:0] RAM_A;
  logic [35:0] RAM_D_po;
  logic [35:0] RAM_D_pi = '0;
  logic        RAM_D_poe, RAM_CE1n, RAM_WEn, RAM_LDn, RAM_OEn, RAM_CENn, busy;

  extram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .RAM_A(RAM_A), .RAM_D_po(RAM_D_po), .RAM_D_pi(RAM_D_pi), .RAM_D_poe(RAM_D_poe),
    .RAM_CE1n(RAM_CE1n), .RAM_WEn(RAM_WEn), .RAM_LDn(RAM_LDn), .RAM_OEn(RAM_OEn),
    .RAM_CENn(RAM_CENn), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [20:0] addr; logic we; int due;} iss_t;
  typedef struct {logic [35:0] d; int due;} wr_t;
  typedef struct {logic port; logic [35:0] d; int due;} rd_t;

  iss_t iq[$];
  wr_t  wq[$];
  rd_t  rq[$];
  int   vectors = 0, miscompares = 0, cyc = 0;
  logic [35:0] a_xd = '0, b_xd = '0;
  logic [35:0] mem [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ZBT model: address/control in cycle n, data on the bus in cycle n+2
  logic        p1_v = 1'b0, p1_we = 1'b0, p2_v = 1'b0, p2_we = 1'b0;
  logic [20:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    if (p2_v && p2_we) mem[int'(p2_a)] = RAM_D_po;
    RAM_D_pi <= (p1_v && !p1_we && mem.exists(int'(p1_a))) ? mem[int'(p1_a)] : 36'h0;
    p2_v  <= p1_v;  p2_we <= p1_we;  p2_a <= p1_a;
    p1_v  <= ~RAM_CE1n;  p1_we <= ~RAM_WEn;  p1_a <= RAM_A;
  end

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    iss_t ie;
    wr_t  we_;
    rd_t  re;
    if (rst_n) begin
      if (!RAM_CE1n) begin
        if (iq.size() == 0) flag("spurious_issue");
        else begin
          ie = iq.pop_front();
          chk("issue_addr", 64'(RAM_A), 64'(ie.addr));
          chk("issue_wen", 64'(RAM_WEn), 64'(!ie.we));
          chk("issue_ldn", 64'(RAM_LDn), 64'(0));
          chk("issue_cycle", 64'(cyc), 64'(ie.due));
        end
      end else if (iq.size() != 0 && iq[0].due < cyc) begin
        void'(iq.pop_front());
        flag("issue_timeout");
      end
      if (!RAM_D_poe) begin
        chk("wr_oen_high", 64'(RAM_OEn), 64'(1));
        if (wq.size() == 0) flag("spurious_write_drive");
        else begin
          we_ = wq.pop_front();
          chk("wr_data", 64'(RAM_D_po), 64'(we_.d));
          chk("wr_cycle", 64'(cyc), 64'(we_.due));
        end
      end else if (wq.size() != 0 && wq[0].due < cyc) begin
        void'(wq.pop_front());
        flag("write_timeout");
      end
      if (a_rvalid || b_rvalid) begin
        if (a_rvalid && b_rvalid) flag("both_rvalid");
        if (rq.size() == 0) flag("spurious_rvalid");
        else begin
          re = rq.pop_front();
          chk("rd_port", 64'(b_rvalid), 64'(re.port));
          chk("rd_data", 64'(b_rvalid ? b_rdata : a_rdata), 64'(re.d));
          chk("rd_cycle", 64'(cyc), 64'(re.due));
        end
      end else if (rq.size() != 0 && rq[0].due < cyc) begin
        void'(rq.pop_front());
        flag("rvalid_timeout");
      end
    end
  end

  task automatic push(input bit p);
    if (!p) begin
      iq.push_back('{a_addr, a_we, cyc + 1});
      if (a_we) wq.push_back('{a_wdata, cyc + 3});
      else      rq.push_back('{1'b0, a_xd, cyc + 4});
    end else begin
      iq.push_back('{b_addr, b_we, cyc + 1});
      if (b_we) wq.push_back('{b_wdata, cyc + 3});
      else      rq.push_back('{1'b1, b_xd, cyc + 4});
    end
  endtask

  // One cycle: check acks mid-cycle, queue expectations, advance past next edge
  task automatic tick(input bit ea, input bit eb, input string nm);
    @(negedge clk);
    chk({nm, "_a_ack"}, 64'(a_ack), 64'(ea));
    chk({nm, "_b_ack"}, 64'(b_ack), 64'(eb));
    if (ea) push(1'b0);
    if (eb) push(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h1FFFFF] = 36'h0_5555_AAAA;
    mem[32'h100]    = 36'hA_0000_0100;
    mem[32'h200]    = 36'hB_0000_0200;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ce1n", 64'(RAM_CE1n), 64'(1));
    chk("rst_wen", 64'(RAM_WEn), 64'(1));
    chk("rst_ldn", 64'(RAM_LDn), 64'(0));
    chk("rst_oen", 64'(RAM_OEn), 64'(1));
    chk("rst_cenn", 64'(RAM_CENn), 64'(1));
    chk("rst_poe", 64'(RAM_D_poe), 64'(1));
    chk("rst_ram_a", 64'(RAM_A), 64'(0));
    chk("rst_po", 64'(RAM_D_po), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("cenn_before_edge", 64'(RAM_CENn), 64'(1));
    @(posedge clk); #1;
    chk("cenn_after_edge", 64'(RAM_CENn), 64'(0));

    // Single A write
    a_req = 1; a_we = 1; a_addr = 21'h00010; a_wdata = 36'h9_ABCD_1234;
    tick(1, 0, "a_write");
    a_req = 0;
    idle(5);

    // Single B read at top of address space
    b_req = 1; b_we = 0; b_addr = 21'h1FFFFF; b_xd = 36'h0_5555_AAAA;
    tick(0, 1, "b_read");
    b_req = 0;
    idle(6);

    // Read then write on A: one bubble cycle
    a_req = 1; a_we = 0; a_addr = 21'h00010; a_xd = 36'h9_ABCD_1234;
    tick(1, 0, "rw_read");
    a_we = 1; a_addr = 21'h00020; a_wdata = 36'h1_2345_6789;
    tick(0, 0, "rw_bubble");
    chk("rw_deselect", 64'(RAM_CE1n), 64'(1));
    tick(1, 0, "rw_write");
    a_req = 0;
    idle(6);

    // Write then read on A: no bubble, read sees fresh data
    a_req = 1; a_we = 1; a_addr = 21'h00030; a_wdata = 36'h0_1111_2222;
    tick(1, 0, "wr_write");
    a_we = 0; a_xd = 36'h0_1111_2222;
    tick(1, 0, "wr_read");
    a_req = 0;
    idle(6);

    b_req = 1; b_we = 0; b_addr = 21'h00020; b_xd = 36'h1_2345_6789;
    tick(0, 1, "b_readback");
    b_req = 0;
    idle(6);

    // Reset with three reads in flight
    b_req = 1; b_we = 0; b_addr = 21'h00040; b_xd = 36'h0;
    tick(0, 1, "inflight0");
    tick(0, 1, "inflight1");
    tick(0, 1, "inflight2");
    chk("busy_inflight", 64'(busy), 64'(1));
    rst_n = 1'b0;
    iq.delete(); wq.delete(); rq.delete();
    #1;
    chk("mid_rst_b_ack", 64'(b_ack), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ce1n", 64'(RAM_CE1n), 64'(1));
    chk("mid_rst_oen", 64'(RAM_OEn), 64'(1));
    chk("mid_rst_cenn", 64'(RAM_CENn), 64'(1));
    chk("mid_rst_ram_a", 64'(RAM_A), 64'(0));
    chk("mid_rst_b_rdata", 64'(b_rdata), 64'(0));
    b_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(6);

    // Both ports reading continuously
    a_req = 1; a_we = 0; a_addr = 21'h00100; a_xd = 36'hA_0000_0100;
    b_req = 1; b_we = 0; b_addr = 21'h00200; b_xd = 36'hB_0000_0200;
    for (int k = 0; k < 40; k++) begin
`ifdef EXTRAM_STRICT_PRIO_EN
      tick(1, 0, "burst");
`else
      tick(((k / 8) % 2) == 0, ((k / 8) % 2) == 1, "burst");
`endif
    end
    a_req = 0;
    tick(0, 1, "a_drop");
    b_req = 0;
    idle(6);

    // ena low blocks grants; raising it re-arms at once
    ena = 0; a_req = 1;
    tick(0, 0, "ena_off0");
    tick(0, 0, "ena_off1");
    ena = 1;
    tick(1, 0, "ena_on");
    a_req = 0;
    idle(8);

    chk("queues_drained", 64'(iq.size() + wq.size() + rq.size()), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
